// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer driving the Datapath_P2 strobes from a step counter and IR opcode.
// Optional build macro SINGLE_STEP_EN: park in PAUSE after each instruction until a Step pulse.
//
//  state   | meaning
//  RESET   | held by Clear, all strobes low, Run high
//  T0..T7  | instruction step; T0-T2 fetch, T3+ execute (Read/Write steps repeat until Mem_ready)
//  HALT    | sticky stop, all strobes low, Run low, left only through Clear
//  PAUSE   | single-step gap between instructions (SINGLE_STEP_EN builds only)
module control_sequencer #(
    parameter int OPC_W        = 5,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic        i_clock,
    input  logic        i_clear,
    input  logic [31:0] i_ir,
    input  logic        i_con_ff,
    input  logic        i_mem_ready,
    input  logic        i_stop,
    input  logic        i_step,
    output logic        o_pcout,
    output logic        o_zhiout,
    output logic        o_zlowout,
    output logic        o_mdrout,
    output logic        o_inportout,
    output logic        o_baout,
    output logic        o_cout,
    output logic        o_marin,
    output logic        o_zin,
    output logic        o_pcin,
    output logic        o_mdrin,
    output logic        o_irin,
    output logic        o_yin,
    output logic        o_outportin,
    output logic        o_rin,
    output logic        o_conin,
    output logic        o_gra,
    output logic        o_grb,
    output logic        o_grc,
    output logic        o_rout,
    output logic        o_incpc,
    output logic        o_read,
    output logic        o_write,
    output logic [3:0]  o_alu_op,
    output logic        o_run
);

    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_T7    = 4'd8;
    localparam logic [3:0] S_HALT  = 4'd9;
`ifdef SINGLE_STEP_EN
    localparam logic [3:0] S_PAUSE = 4'd10;
    localparam logic [3:0] S_DONE  = S_PAUSE;
`else
    localparam logic [3:0] S_DONE  = S_T0;
`endif

    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'b00000);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5'b00001);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(5'b00010);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b01100);
    localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(5'b10010);
    localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(5'b10011);
    localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(5'b10100);
    localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(5'b10101);
    localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(5'b10110);
    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(5'b11001);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11010);

    logic [3:0]       r_state;
    logic             r_wait;
    logic             r_con;
    logic [3:0]       w_state_next;
    logic             w_hold;
    logic [OPC_W-1:0] w_opc;
    logic             w_op_ld, w_op_ldi, w_op_st, w_op_addi, w_op_br, w_op_jr;
    logic             w_op_jal, w_op_in, w_op_out, w_op_nop, w_op_halt;
    logic             w_is_alu, w_illegal, w_mem_step, w_last_step, w_halt_step;
    logic [3:0]       w_alu_code;
    logic             w_unused;

    assign w_opc     = i_ir[31 -: OPC_W];
    assign w_unused  = &{1'b0, i_ir[31-OPC_W:0], i_step};

    assign w_op_ld   = (w_opc == OP_LD);
    assign w_op_ldi  = (w_opc == OP_LDI);
    assign w_op_st   = (w_opc == OP_ST);
    assign w_op_addi = (w_opc == OP_ADDI);
    assign w_op_br   = (w_opc == OP_BR);
    assign w_op_jr   = (w_opc == OP_JR);
    assign w_op_jal  = (w_opc == OP_JAL);
    assign w_op_in   = (w_opc == OP_IN);
    assign w_op_out  = (w_opc == OP_OUT);
    assign w_op_nop  = (w_opc == OP_NOP);
    assign w_op_halt = (w_opc == OP_HALT);
    assign w_is_alu  = (w_opc == OP_ADD) || (w_opc == OP_SUB) ||
                       (w_opc == OP_AND) || (w_opc == OP_OR);
    assign w_illegal = !(w_is_alu || w_op_ld || w_op_ldi || w_op_st || w_op_addi || w_op_br ||
                         w_op_jr || w_op_jal || w_op_in || w_op_out || w_op_nop || w_op_halt);

    assign w_alu_code = (w_opc == OP_SUB) ? 4'd1 :
                        (w_opc == OP_AND) ? 4'd2 :
                        (w_opc == OP_OR)  ? 4'd3 : 4'd0;

    assign w_mem_step  = (r_state == S_T1) || (r_state == S_T6 && w_op_ld) ||
                         (r_state == S_T7 && w_op_st);
    assign w_halt_step = (r_state == S_T3) && (w_op_halt || (w_illegal && ILLEGAL_HALT));
    // T7 is always terminal so a corrupted IR can never walk the counter into HALT's code.
    assign w_last_step = (r_state == S_T3 && (w_op_jr || w_op_in || w_op_out || w_op_nop || w_illegal)) ||
                         (r_state == S_T4 && w_op_jal) ||
                         (r_state == S_T5 && (w_is_alu || w_op_addi || w_op_ldi)) ||
                         (r_state == S_T6 && w_op_br) ||
                         (r_state == S_T7);

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state <= S_RESET;
            r_wait  <= 1'b0;
            r_con   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_hold;
            if (r_state == S_T5) r_con <= i_con_ff;
        end
    end

    always_comb begin
        w_state_next = S_RESET;
        w_hold       = 1'b0;
        case (r_state)
            S_RESET: w_state_next = S_T0;
            S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
                w_hold = w_mem_step && !i_mem_ready;
                if (w_hold)           w_state_next = r_state;
                else if (w_halt_step) w_state_next = S_HALT;
                else if (w_last_step) w_state_next = i_stop ? S_HALT : S_DONE;
                else                  w_state_next = r_state + 4'd1;
            end
            S_HALT:  w_state_next = S_HALT;
`ifdef SINGLE_STEP_EN
            S_PAUSE: w_state_next = i_stop ? S_HALT : (i_step ? S_T0 : S_PAUSE);
`endif
            default: w_state_next = S_RESET;
        endcase
    end

    always_comb begin
        o_pcout = 1'b0; o_zhiout = 1'b0; o_zlowout = 1'b0; o_mdrout = 1'b0;
        o_inportout = 1'b0; o_baout = 1'b0; o_cout = 1'b0;
        o_marin = 1'b0; o_zin = 1'b0; o_pcin = 1'b0; o_mdrin = 1'b0; o_irin = 1'b0;
        o_yin = 1'b0; o_outportin = 1'b0; o_rin = 1'b0; o_conin = 1'b0;
        o_gra = 1'b0; o_grb = 1'b0; o_grc = 1'b0; o_rout = 1'b0;
        o_incpc = 1'b0; o_read = 1'b0; o_write = 1'b0;
        o_alu_op = 4'd0;
        o_run = (r_state != S_HALT);
        case (r_state)
            S_T0: begin o_pcout = 1'b1; o_marin = 1'b1; o_incpc = 1'b1; o_zin = 1'b1; end
            // PC must load only once even if the fetch read stretches.
            S_T1: begin o_zlowout = 1'b1; o_pcin = !r_wait; o_read = 1'b1; o_mdrin = 1'b1; end
            S_T2: begin o_mdrout = 1'b1; o_irin = 1'b1; end
            S_T3: begin
                if (w_is_alu || w_op_addi) begin o_grb = 1'b1; o_rout = 1'b1; o_yin = 1'b1; end
                else if (w_op_ld || w_op_ldi || w_op_st) begin o_grb = 1'b1; o_baout = 1'b1; o_yin = 1'b1; end
                else if (w_op_br) begin o_gra = 1'b1; o_rout = 1'b1; o_conin = 1'b1; end
                else if (w_op_jr) begin o_gra = 1'b1; o_rout = 1'b1; o_pcin = 1'b1; end
                else if (w_op_jal) begin o_pcout = 1'b1; o_grb = 1'b1; o_rin = 1'b1; end
                else if (w_op_in) begin o_inportout = 1'b1; o_gra = 1'b1; o_rin = 1'b1; end
                else if (w_op_out) begin o_gra = 1'b1; o_rout = 1'b1; o_outportin = 1'b1; end
            end
            S_T4: begin
                if (w_is_alu) begin o_grc = 1'b1; o_rout = 1'b1; o_zin = 1'b1; o_alu_op = w_alu_code; end
                else if (w_op_addi || w_op_ldi || w_op_ld || w_op_st) begin o_cout = 1'b1; o_zin = 1'b1; end
                else if (w_op_br) begin o_pcout = 1'b1; o_yin = 1'b1; end
                else if (w_op_jal) begin o_gra = 1'b1; o_rout = 1'b1; o_pcin = 1'b1; end
            end
            S_T5: begin
                if (w_is_alu || w_op_addi || w_op_ldi) begin o_zlowout = 1'b1; o_gra = 1'b1; o_rin = 1'b1; end
                else if (w_op_ld || w_op_st) begin o_zlowout = 1'b1; o_marin = 1'b1; end
                else if (w_op_br) begin o_cout = 1'b1; o_zin = 1'b1; end
            end
            S_T6: begin
                if (w_op_ld) begin o_read = 1'b1; o_mdrin = 1'b1; end
                else if (w_op_st) begin o_gra = 1'b1; o_rout = 1'b1; o_mdrin = 1'b1; end
                else if (w_op_br && r_con) begin o_zlowout = 1'b1; o_pcin = 1'b1; end
            end
            S_T7: begin
                if (w_op_ld) begin o_mdrout = 1'b1; o_gra = 1'b1; o_rin = 1'b1; end
                else if (w_op_st) o_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a per-instruction micro-step list predicts every cycle's strobes.
module tb_control_sequencer;
    localparam bit ILLEGAL_HALT = 1'b1;

    localparam logic [27:0] PCOUT = 28'd1 << 0,  ZHIOUT = 28'd1 << 1,  ZLOWOUT = 28'd1 << 2;
    localparam logic [27:0] MDROUT = 28'd1 << 3, INPORTOUT = 28'd1 << 4, BAOUT = 28'd1 << 5;
    localparam logic [27:0] COUT = 28'd1 << 6,   MARIN = 28'd1 << 7,   ZIN = 28'd1 << 8;
    localparam logic [27:0] PCIN = 28'd1 << 9,   MDRIN = 28'd1 << 10,  IRIN = 28'd1 << 11;
    localparam logic [27:0] YIN = 28'd1 << 12,   OUTPORTIN = 28'd1 << 13, RIN = 28'd1 << 14;
    localparam logic [27:0] CONIN = 28'd1 << 15, GRA = 28'd1 << 16,    GRB = 28'd1 << 17;
    localparam logic [27:0] GRC = 28'd1 << 18,   ROUT = 28'd1 << 19,   INCPC = 28'd1 << 20;
    localparam logic [27:0] READ = 28'd1 << 21,  WRITE = 28'd1 << 22,  RUN = 28'd1 << 27;

    typedef struct {
        logic [27:0] v;
        bit          mem;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear, con_ff, mem_ready, stop, step;
    logic [31:0] ir;
    logic pcout, zhiout, zlowout, mdrout, inportout, baout, cout;
    logic marin, zin, pcin, mdrin, irin, yin, outportin, rin, conin;
    logic gra, grb, grc, rout, incpc, read, write, run;
    logic [3:0] alu_op;

    logic [27:0] obs;
    assign obs = {run, alu_op, write, read, incpc, rout, grc, grb, gra, conin, rin, outportin,
                  yin, irin, mdrin, pcin, zin, marin, cout, baout, inportout, mdrout, zlowout,
                  zhiout, pcout};

    control_sequencer #(.OPC_W(5), .ILLEGAL_HALT(ILLEGAL_HALT)) dut (
        .i_clock(clk), .i_clear(clear), .i_ir(ir), .i_con_ff(con_ff), .i_mem_ready(mem_ready),
        .i_stop(stop), .i_step(step),
        .o_pcout(pcout), .o_zhiout(zhiout), .o_zlowout(zlowout), .o_mdrout(mdrout),
        .o_inportout(inportout), .o_baout(baout), .o_cout(cout), .o_marin(marin), .o_zin(zin),
        .o_pcin(pcin), .o_mdrin(mdrin), .o_irin(irin), .o_yin(yin), .o_outportin(outportin),
        .o_rin(rin), .o_conin(conin), .o_gra(gra), .o_grb(grb), .o_grc(grc), .o_rout(rout),
        .o_incpc(incpc), .o_read(read), .o_write(write), .o_alu_op(alu_op), .o_run(run)
    );

    logic [27:0] exp_q[$];
    step_t       prog[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [27:0] mon_exp;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            n_checks++;
            if (obs !== mon_exp) begin
                n_errors++;
                $display("FAIL strobes t=%0t ir_op=%b got=%h expected=%h", $time, ir[31:27], obs, mon_exp);
            end
        end
    end

    function automatic void add(input logic [27:0] v, input bit m);
        prog.push_back('{v: v, mem: m});
    endfunction

    // Micro-step list for one instruction, written straight from the step table.
    function automatic void build(input logic [4:0] opc, input bit con, output bit halts);
        prog.delete();
        halts = 1'b0;
        add(PCOUT | MARIN | INCPC | ZIN, 1'b0);
        add(ZLOWOUT | PCIN | READ | MDRIN, 1'b1);
        add(MDROUT | IRIN, 1'b0);
        case (opc)
            5'b00000: begin
                add(GRB | BAOUT | YIN, 0); add(COUT | ZIN, 0); add(ZLOWOUT | MARIN, 0);
                add(READ | MDRIN, 1); add(MDROUT | GRA | RIN, 0);
            end
            5'b00001: begin add(GRB | BAOUT | YIN, 0); add(COUT | ZIN, 0); add(ZLOWOUT | GRA | RIN, 0); end
            5'b00010: begin
                add(GRB | BAOUT | YIN, 0); add(COUT | ZIN, 0); add(ZLOWOUT | MARIN, 0);
                add(GRA | ROUT | MDRIN, 0); add(WRITE, 1);
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                add(GRB | ROUT | YIN, 0);
                add(GRC | ROUT | ZIN | (28'(int'(opc) - 3) << 23), 0);
                add(ZLOWOUT | GRA | RIN, 0);
            end
            5'b01100: begin add(GRB | ROUT | YIN, 0); add(COUT | ZIN, 0); add(ZLOWOUT | GRA | RIN, 0); end
            5'b10010: begin
                add(GRA | ROUT | CONIN, 0); add(PCOUT | YIN, 0); add(COUT | ZIN, 0);
                add(con ? (ZLOWOUT | PCIN) : 28'd0, 0);
            end
            5'b10011: add(GRA | ROUT | PCIN, 0);
            5'b10100: begin add(PCOUT | GRB | RIN, 0); add(GRA | ROUT | PCIN, 0); end
            5'b10101: add(INPORTOUT | GRA | RIN, 0);
            5'b10110: add(GRA | ROUT | OUTPORTIN, 0);
            5'b11001: add(28'd0, 0);
            5'b11010: begin add(28'd0, 0); halts = 1'b1; end
            default:  begin add(28'd0, 0); halts = ILLEGAL_HALT; end
        endcase
    endfunction

    task automatic cycle(input logic [27:0] e, input bit mr, input bit stp, input bit stv, input bit clr);
        exp_q.push_back(e);
        mem_ready = mr;
        stop      = stp;
        step      = stv;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [4:0] opc, input bit con, input bit stop_end,
                             input int exec_wait, input int abort_at, output bit halted);
        bit halts;
        build(opc, con, halts);
        ir     = {opc, 27'($urandom)};
        con_ff = con;
        halted = 1'b0;
        for (int s = 0; s < prog.size(); s++) begin
            int waits;
            bit last;
            waits = 0;
            if (prog[s].mem)
                waits = (s == 1) ? int'($urandom_range(0, 2)) :
                        ((exec_wait < 0) ? int'($urandom_range(0, 3)) : exec_wait);
            last = (s == prog.size() - 1);
            if (s == abort_at) begin
                cycle(prog[s].v | RUN, 1'b0, 1'b0, 1'b0, 1'b1);
                cycle(RUN, 1'b1, 1'b0, 1'b0, 1'b0);
                return;
            end
            for (int c = 0; c <= waits; c++) begin
                logic [27:0] e;
                bit mr, stp;
                e = prog[s].v | RUN;
                if (s == 1 && c > 0) e = e & ~PCIN;
                mr  = prog[s].mem ? (c == waits) : 1'($urandom);
                stp = (last && c == waits) ? stop_end : ($urandom_range(0, 3) == 0);
                cycle(e, mr, stp, 1'($urandom), 1'b0);
            end
        end
        halted = halts || stop_end;
`ifdef SINGLE_STEP_EN
        if (!halted) begin
            repeat ($urandom_range(0, 3)) cycle(RUN, 1'($urandom), 1'b0, 1'b0, 1'b0);
            if ($urandom_range(0, 7) == 0) begin
                cycle(RUN, 1'b1, 1'b1, 1'b1, 1'b0);
                halted = 1'b1;
            end else begin
                cycle(RUN, 1'($urandom), 1'b0, 1'b1, 1'b0);
            end
        end
`endif
    endtask

    task automatic halt_and_clear(input int n);
        repeat (n) cycle(28'd0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        cycle(28'd0, 1'($urandom), 1'b0, 1'b0, 1'b1);
        cycle(RUN, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(RUN, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] legal [15];
        logic [4:0] opc;
        bit h;
        legal = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100,
                  5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b11001, 5'b11010};
        clear = 1'b1; ir = 32'd0; con_ff = 1'b0; mem_ready = 1'b1; stop = 1'b0; step = 1'b0;
        @(posedge clk);
        #1;
        cycle(RUN, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(RUN, 1'b1, 1'b0, 1'b0, 1'b0);

        run_instr(5'b00011, 1'b0, 1'b0, -1, -1, h);
        run_instr(5'b00000, 1'b0, 1'b0, 3, -1, h);
        run_instr(5'b10010, 1'b0, 1'b0, -1, -1, h);
        run_instr(5'b10010, 1'b1, 1'b0, -1, -1, h);
        run_instr(5'b00100, 1'b0, 1'b0, -1, -1, h);
        run_instr(5'b11010, 1'b0, 1'b0, -1, -1, h);
        halt_and_clear(4);
        run_instr(5'b00010, 1'b0, 1'b0, 2, 7, h);
        run_instr(5'b01000, 1'b0, 1'b0, -1, -1, h);
        if (h) halt_and_clear(2);
        run_instr(5'b00110, 1'b0, 1'b1, -1, -1, h);
        halt_and_clear(3);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) opc = 5'($urandom);
            else                           opc = legal[$urandom_range(0, 14)];
            run_instr(opc, 1'($urandom), $urandom_range(0, 15) == 0, -1,
                      ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 7)) : -1, h);
            if (h) halt_and_clear(int'($urandom_range(1, 4)));
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
